// File: rtl/alu_cmd_sequencer.sv
// FIFO-buffered command driver for the 6-bit ALU; result valid SETTLE_CYCLES+2 cycles after pop, held until res_ready.
// cmd_ready drops when the FIFO is full. Defining ALU_SEQ_CHECK_EN adds a reference check and the mismatch output.
module alu_cmd_sequencer #(
   parameter int FIFO_DEPTH    = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [5:0] cmd_a,
   input  logic [5:0] cmd_b,
   input  logic [2:0] cmd_op,
   output logic [5:0] alu_input1,
   output logic [5:0] alu_input2,
   output logic       alu_f,
   output logic       alu_x,
   output logic       alu_n,
   input  logic [5:0] alu_result,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [5:0] res_data,
   output logic [2:0] res_op,
   output logic       busy
`ifdef ALU_SEQ_CHECK_EN
   ,
   output logic       mismatch
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [5:0] a;
      logic [5:0] b;
      logic [2:0] op;
   } cmd_t;

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CAPTURE, HOLD} state_t;

   state_t        state, state_nxt;
   cmd_t          mem [FIFO_DEPTH];
   cmd_t          head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [3:0]    settle_cnt;
   logic          push, pop;

   // Full test uses the registered count, so a push is refused when full even if a pop happens that cycle.
   assign cmd_ready = (count != CW'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == IDLE) && (count != '0);
   assign busy      = (count != '0) || (state != IDLE);
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_CHECK_EN
   function automatic logic [5:0] ref_alu(input logic [5:0] a, input logic [5:0] b, input logic [2:0] op);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return -a;
         3'b011:  return -b;
         3'b100:  return ~(a ^ b);
         3'b101:  return {5'b0, (b > a)};
         default: return '0;
      endcase
   endfunction
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (count != '0) state_nxt = DRIVE;
         DRIVE:   state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == '0) state_nxt = CAPTURE;
         CAPTURE: state_nxt = HOLD;
         HOLD:    if (res_valid && res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         alu_input1 <= '0;
         alu_input2 <= '0;
         alu_f      <= 1'b0;
         alu_x      <= 1'b0;
         alu_n      <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_op     <= '0;
`ifdef ALU_SEQ_CHECK_EN
         mismatch   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         // Drive registers keep the last command between transactions.
         if (pop) begin
            alu_input1 <= head.a;
            alu_input2 <= head.b;
            {alu_f, alu_x, alu_n} <= head.op;
         end
         if (state == DRIVE) begin
            settle_cnt <= 4'(SETTLE_CYCLES - 1);
         end else if (state == SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 4'd1;
         end
         if (state == CAPTURE) begin
            res_data  <= alu_result;
            res_op    <= {alu_f, alu_x, alu_n};
            res_valid <= 1'b1;
`ifdef ALU_SEQ_CHECK_EN
            mismatch  <= (alu_result != ref_alu(alu_input1, alu_input2, {alu_f, alu_x, alu_n}));
`endif
         end else if (state == HOLD && res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: spec-level result model with a scoreboard queue, plus literal checks.
module tb_alu_cmd_sequencer;

   localparam int FD = 4;
   localparam int S  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [5:0] cmd_a, cmd_b;
   logic [2:0] cmd_op;
   logic [5:0] alu_input1, alu_input2;
   logic       alu_f, alu_x, alu_n;
   logic [5:0] alu_result;
   logic       res_valid, res_ready;
   logic [5:0] res_data;
   logic [2:0] res_op;
   logic       busy;
   logic       fault_en;
`ifdef ALU_SEQ_CHECK_EN
   logic       mismatch;
`endif

   int vectors = 0;
   int errors  = 0;
   int hs_count = 0;

   typedef struct {
      int d;
      int op;
      int mm;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.FIFO_DEPTH(FD), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_input1(alu_input1), .alu_input2(alu_input2),
      .alu_f(alu_f), .alu_x(alu_x), .alu_n(alu_n),
      .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_op(res_op),
      .busy(busy)
`ifdef ALU_SEQ_CHECK_EN
      , .mismatch(mismatch)
`endif
   );

   // Opcode map in plain integer arithmetic, results reduced mod 64.
   function automatic int alu_map(input int a, input int b, input int op);
      case (op)
         0:       return (a + b) % 64;
         1:       return (a - b + 64) % 64;
         2:       return (64 - a) % 64;
         3:       return (64 - b) % 64;
         4:       return 63 - (a ^ b);
         5:       return (b > a) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   // Behavioural ALU; the fault makes op 100 return 0.
   always_comb begin
      alu_result = 6'(alu_map(int'(alu_input1), int'(alu_input2), int'({alu_f, alu_x, alu_n})));
      if (fault_en && {alu_f, alu_x, alu_n} == 3'b100) alu_result = '0;
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      errors++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Scoreboard: accepted commands enqueue expected results; each result handshake is checked in order.
   logic hold_prev = 1'b0;
   int   hold_d, hold_op;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", int'(res_valid), 1);
            check("hold_data", int'(res_data), hold_d);
            check("hold_op", int'(res_op), hold_op);
         end
         if (res_valid && res_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
               timeout("unexpected_result");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("model_data", int'(res_data), e.d);
               check("model_op", int'(res_op), e.op);
`ifdef ALU_SEQ_CHECK_EN
               check("model_mismatch", int'(mismatch), e.mm);
`endif
            end
         end
         hold_prev = res_valid && !res_ready;
         hold_d    = int'(res_data);
         hold_op   = int'(res_op);
         if (cmd_valid && cmd_ready) begin
            exp_t n;
            int   good;
            good = alu_map(int'(cmd_a), int'(cmd_b), int'(cmd_op));
            n.op = int'(cmd_op);
            n.d  = (fault_en && cmd_op == 3'b100) ? 0 : good;
            n.mm = (fault_en && cmd_op == 3'b100 && good != 0) ? 1 : 0;
            exp_q.push_back(n);
         end
      end
   end

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic push_cmd(input logic [5:0] a, input logic [5:0] b, input logic [2:0] op);
      int n = 0;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout("push");
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      @(negedge clk);
      while (!res_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (!res_valid) timeout("wait_res_valid");
   endtask

   // Push into an idle sequencer: pop is one edge after the push, result S+2 edges after the pop.
   task automatic run_one(input logic [5:0] a, input logic [5:0] b, input logic [2:0] op, input int exp_d);
      int lat;
      push_cmd(a, b, op);
      wait_valid(lat);
      check("latency_after_pop", lat - 1, S + 2);
      check("lit_data", int'(res_data), exp_d);
      check("lit_op", int'(res_op), int'(op));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat, base, n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
      res_ready = 1'b1; fault_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_res_valid", int'(res_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_alu", int'({alu_input1, alu_input2, alu_f, alu_x, alu_n}), 0);
      check("rst_res", int'({res_data, res_op}), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      run_one(6'd5, 6'd3, 3'b000, 8);
      run_one(6'd3, 6'd5, 3'b001, 62);
      run_one(6'd1, 6'd0, 3'b010, 63);
      run_one(6'd0, 6'd1, 3'b011, 63);
      run_one(6'd2, 6'd7, 3'b101, 1);
      run_one(6'd42, 6'd38, 3'b100, 51);
      run_one(6'd7, 6'd9, 3'b110, 0);

      // Backpressure: five back-to-back commands fill FSM plus FIFO; a sixth is refused.
      base = hs_count;
      res_ready = 1'b0;
      push_cmd(6'd10, 6'd20, 3'b000);
      push_cmd(6'd1, 6'd2, 3'b001);
      push_cmd(6'd4, 6'd0, 3'b010);
      push_cmd(6'd0, 6'd5, 3'b011);
      push_cmd(6'd3, 6'd3, 3'b100);
      @(negedge clk);
      check("full_cmd_ready", int'(cmd_ready), 0);
      check("full_busy", int'(busy), 1);
      cmd_a = 6'd7; cmd_b = 6'd7; cmd_op = 3'b000; cmd_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("refused_cmd_ready", int'(cmd_ready), 0);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_res_valid", int'(res_valid), 1);
         check("hold_res_data", int'(res_data), 30);
         check("hold_res_op", int'(res_op), 0);
         check("hold_busy", int'(busy), 1);
      end
      @(posedge clk);
      #1 res_ready = 1'b1;
      n = 0;
      while (hs_count - base < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      check("drain_count", hs_count - base, 5);
      check("drain_queue_empty", exp_q.size(), 0);
      check("drain_busy", int'(busy), 0);

      // Reset during SETTLE aborts the command with no result.
      @(posedge clk);
      #1;
      push_cmd(6'd9, 6'd5, 3'b011);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("pre_rst_alu_input1", int'(alu_input1), 9);
      @(negedge clk);
      check("abort_res_valid", int'(res_valid), 0);
      check("abort_cmd_ready", int'(cmd_ready), 1);
      check("abort_busy", int'(busy), 0);
      check("abort_alu", int'({alu_input1, alu_input2, alu_f, alu_x, alu_n}), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      base = hs_count;
      repeat (12) @(negedge clk);
      check("abort_no_result", hs_count - base, 0);
      @(posedge clk);
      #1;

`ifdef ALU_SEQ_CHECK_EN
      fault_en = 1'b1;
      run_one(6'd42, 6'd38, 3'b100, 0);
      check("fault_mismatch", int'(mismatch), 1);
      run_one(6'd5, 6'd3, 3'b000, 8);
      check("good_mismatch", int'(mismatch), 0);
      fault_en = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
